// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult8_seq_ctrl
//  Description : Sequential 8x8 signed shift-add multiplier. A control FSM
//                steps a 17-bit {X,A,B} datapath through one add/subtract and
//                one arithmetic right shift per multiplier bit. The 16-bit
//                two's-complement product ends up in A:B, with X holding the
//                sign extension. Bit 7 (the multiplier sign) is handled by
//                subtracting the multiplicand instead of adding it.
//  Ports       : Clk          - system clock, rising edge
//                Reset_n      - asynchronous active-low reset
//                Run          - start request (level, synchronous)
//                ClearA_LoadB - in IDLE: clear A/X and load B from S
//                S[7:0]       - multiplicand; also the load value for B
//                Aval[7:0]    - register A (high product byte)
//                Bval[7:0]    - register B (multiplier, then low byte)
//                Xval         - sign-extension bit X
//                Busy         - high from CLR through SHIFT7
//                Done         - high while the result is held in DONE
//  Options     : MULT_SKIP_ADD_EN - when defined, add cycles for multiplier
//                bits that are 0 are skipped (Busy = 9 + popcount(B) cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult8_seq_ctrl (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] S,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Xval,
    output logic       Busy,
    output logic       Done
);

    // The eight ADDi/SHIFTi pairs share one phase encoding each; r_bit holds i.
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLR   = 3'd1;
    localparam logic [2:0] c_ST_ADD   = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] r_bit;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_x;
    logic       r_busy;
    logic       r_done;

    logic [2:0] w_state_nxt;
    logic [2:0] w_bit_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    // 9-bit add/subtract stage controls: M selects add vs. pass-through,
    // fn selects subtract (only for the sign bit of the multiplier).
    logic       w_m;
    logic       w_fn;
    logic [8:0] w_operand;
    logic [8:0] w_sum;

    assign w_m       = r_b[0];
    assign w_fn      = (r_bit == 3'd7);
    assign w_operand = {S[7], S} ^ {9{w_fn}};
    // Carry out of bit 8 is dropped; 9 bits are enough for an exact result.
    assign w_sum     = {r_a[7], r_a} + w_operand + {8'd0, w_fn};

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        case (r_state)
            c_ST_IDLE: begin
                // A load takes priority; Run is re-sampled next cycle.
                if (!ClearA_LoadB && Run) begin
                    w_state_nxt = c_ST_CLR;
                end
            end
            c_ST_CLR: begin
                w_bit_nxt = 3'd0;
`ifdef MULT_SKIP_ADD_EN
                w_state_nxt = r_b[0] ? c_ST_ADD : c_ST_SHIFT;
`else
                w_state_nxt = c_ST_ADD;
`endif
            end
            c_ST_ADD: begin
                w_state_nxt = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (r_bit == 3'd7) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_bit_nxt = r_bit + 3'd1;
`ifdef MULT_SKIP_ADD_EN
                    // B[1] becomes B[0] after this shift.
                    w_state_nxt = r_b[1] ? c_ST_ADD : c_ST_SHIFT;
`else
                    w_state_nxt = c_ST_ADD;
`endif
                end
            end
            c_ST_DONE: begin
                if (!Run) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    assign w_busy_nxt = (w_state_nxt == c_ST_CLR) || (w_state_nxt == c_ST_ADD) ||
                        (w_state_nxt == c_ST_SHIFT);
    assign w_done_nxt = (w_state_nxt == c_ST_DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_ST_IDLE;
            r_bit   <= 3'd0;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    if (ClearA_LoadB) begin
                        r_a <= 8'h00;
                        r_x <= 1'b0;
                        r_b <= S;
                    end
                end
                c_ST_CLR: begin
                    // B is kept so a previous product can serve as multiplier.
                    r_a <= 8'h00;
                    r_x <= 1'b0;
                end
                c_ST_ADD: begin
                    if (w_m) begin
                        {r_x, r_a} <= w_sum;
                    end else begin
                        r_x <= r_a[7];
                    end
                end
                c_ST_SHIFT: begin
                    // X is left alone: after the shift A[7] equals X, so a
                    // skipped ADD (X <= A[7]) needs no extra update.
                    r_b <= {r_a[0], r_b[7:1]};
                    r_a <= {r_x, r_a[7:1]};
                end
                default: begin
                end
            endcase
        end
    end

    assign Aval = r_a;
    assign Bval = r_b;
    assign Xval = r_x;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult8_seq_ctrl
//  Description : Self-checking bench for mult8_seq_ctrl. Directed multiplies
//                push their expected product and Busy length into a queue;
//                a monitor pops and compares whenever Done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult8_seq_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Busy;
    logic       Done;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
        int         busy;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    mult8_seq_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Busy         (Busy),
        .Done         (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endfunction

    function automatic int exp_busy(input logic [7:0] mb);
`ifdef MULT_SKIP_ADD_EN
        return 9 + $countones(mb);
`else
        return 17 + 0 * $countones(mb);
`endif
    endfunction

    // Monitor: counts Busy cycles and compares each result when Done rises.
    initial begin : monitor
        int   busy_cnt;
        logic prev_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (Busy && Done) begin
                    chk("busy_done_overlap", 1, 0);
                end
                if (Busy) busy_cnt++;
                if (Done && !prev_done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result_a", int'(Aval), int'(e.a));
                        chk("result_b", int'(Bval), int'(e.b));
                        chk("result_x", int'(Xval), int'(e.x));
                        chk("busy_cycles", busy_cnt, e.busy);
                    end
                    busy_cnt = 0;
                end
                prev_done = Done;
            end
        end
    end

    task automatic load_b(input logic [7:0] s);
        @(negedge Clk);
        S = s;
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        chk("load_b", int'(Bval), int'(s));
        chk("load_a", int'(Aval), 0);
        chk("load_x", int'(Xval), 0);
    endtask

    // with_load: ClearA_LoadB raised together with Run.
    // clr_pulse: ClearA_LoadB pulsed mid-multiply (must be ignored).
    task automatic run_mult(input logic [7:0] s, input logic [7:0] mb,
                            input logic [7:0] ea, input logic [7:0] eb,
                            input logic ex, input logic with_load,
                            input logic clr_pulse);
        exp_t e;
        bit   seen;
        @(negedge Clk);
        S = s;
        Run = 1'b1;
        ClearA_LoadB = with_load;
        e.a = ea;
        e.b = eb;
        e.x = ex;
        e.busy = exp_busy(mb);
        sb.push_back(e);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (with_load && i == 0) begin
                chk("both_high_b", int'(Bval), int'(s));
                chk("both_high_a", int'(Aval), 0);
                chk("both_high_busy", int'(Busy), 0);
            end
            ClearA_LoadB = (clr_pulse && i == 4);
            if (Done) begin
                seen = 1;
                break;
            end
        end
        ClearA_LoadB = 1'b0;
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end
        @(negedge Clk);
        chk("done_hold", int'(Done), 1);
        Run = 1'b0;
        @(negedge Clk);
        chk("done_clear", int'(Done), 0);
        chk("idle_busy", int'(Busy), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        total = 0;
        bad   = 0;
        Reset_n = 1'b0;
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        S = 8'h00;
        repeat (2) @(negedge Clk);
        chk("rst_a", int'(Aval), 0);
        chk("rst_b", int'(Bval), 0);
        chk("rst_x", int'(Xval), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        Reset_n = 1'b1;

        // 7 x -3 = -21 = 0xFFEB
        load_b(8'h07);
        run_mult(8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b1, 1'b0, 1'b0);
        // chained: -21 x 2 = -42 = 0xFFD6
        run_mult(8'h02, 8'hEB, 8'hFF, 8'hD6, 1'b1, 1'b0, 1'b0);
        // -128 x -128 = 0x4000
        load_b(8'h80);
        run_mult(8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        // -1 x -1 = 1
        load_b(8'hFF);
        run_mult(8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        // load and Run together: 3 x 3 = 9
        run_mult(8'h03, 8'h03, 8'h00, 8'h09, 1'b0, 1'b1, 1'b0);
        // chained 9 x 5 = 45, ClearA_LoadB pulsed while busy
        run_mult(8'h05, 8'h09, 8'h00, 8'h2D, 1'b0, 1'b0, 1'b1);
        // zero multiplier
        load_b(8'h00);
        run_mult(8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        // 1 x 5 = 5
        load_b(8'h01);
        run_mult(8'h05, 8'h01, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
        // -128 x 127 = -16256 = 0xC080
        load_b(8'h80);
        run_mult(8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a multiply
        load_b(8'h6D);
        @(negedge Clk);
        S = 8'h33;
        Run = 1'b1;
        repeat (9) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_a", int'(Aval), 0);
        chk("midrst_b", int'(Bval), 0);
        chk("midrst_x", int'(Xval), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_done", int'(Done), 0);
        Run = 1'b0;
        @(negedge Clk);
        #2;
        Reset_n = 1'b1;

        // normal operation after reset: 127 x 127 = 16129 = 0x3F01
        load_b(8'h7F);
        run_mult(8'h7F, 8'h7F, 8'h3F, 8'h01, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge Clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
